// File: rtl/branch_pkg.sv
// rtl/branch_pkg.sv - state encodings and condition codes shared by the branch sequencer
package branch_pkg;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_EVAL = 3'd1;
    localparam logic [2:0] ST_LDPC = 3'd2;
    localparam logic [2:0] ST_ADD  = 3'd3;
    localparam logic [2:0] ST_UPD  = 3'd4;

    localparam logic [1:0] COND_ZR = 2'b00;
    localparam logic [1:0] COND_NZ = 2'b01;
    localparam logic [1:0] COND_PL = 2'b10;
    localparam logic [1:0] COND_MI = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE = ST_IDLE,
        S_EVAL = ST_EVAL,
        S_LDPC = ST_LDPC,
        S_ADD  = ST_ADD,
        S_UPD  = ST_UPD
    } state_t;

endpackage

// File: rtl/branch_seq_if.sv
// rtl/branch_seq_if.sv - control-unit handshake and datapath strobes of the branch sequencer
interface branch_seq_if #(
    parameter int BITS = 32
) ();

    logic            start;
    logic [1:0]      ir_c2;
    logic [BITS-1:0] bus;

    logic            busy;
    logic            done;
    logic            taken;
    logic            gra;
    logic            rout;
    logic            con_in;
    logic            pc_out;
    logic            y_in;
    logic            c_out;
    logic            alu_add;
    logic            z_in;
    logic            zlow_out;
    logic            pc_in;

    modport master (
        output start, ir_c2, bus,
        input  busy, done, taken, gra, rout, con_in, pc_out, y_in,
               c_out, alu_add, z_in, zlow_out, pc_in
    );

    modport slave (
        input  start, ir_c2, bus,
        output busy, done, taken, gra, rout, con_in, pc_out, y_in,
               c_out, alu_add, z_in, zlow_out, pc_in
    );

endinterface

// File: rtl/branch_cond_eval.sv
// rtl/branch_cond_eval.sv - combinational branch condition test on a bus value
module branch_cond_eval
    import branch_pkg::*;
#(
    parameter int BITS = 32
) (
    input  logic [1:0]      cond,
    input  logic [BITS-1:0] value,
    output logic            met
);

    // Zero counts as plus: PL looks only at the sign bit.
    always_comb begin
        met = 1'b0;
        case (cond)
            COND_ZR: met = (value == '0);
            COND_NZ: met = (value != '0);
            COND_PL: met = ~value[BITS-1];
            default: met = value[BITS-1];
        endcase
    end

endmodule

// File: rtl/branch_seq.sv
// rtl/branch_seq.sv - multi-cycle sequencer for brzr/brnz/brpl/brmi
module branch_seq
    import branch_pkg::*;
#(
    parameter int BITS = 32
) (
    input  logic         clk,
    input  logic         clr,
    branch_seq_if.slave  bif
);

    state_t     state;
    logic [1:0] cond_r;
    logic       met;

    branch_cond_eval #(.BITS(BITS)) u_cond_eval (
        .cond  (cond_r),
        .value (bif.bus),
        .met   (met)
    );

    // Strobes are registered alongside the state: each branch loads the
    // outputs that belong to the state being entered.
    always_ff @(posedge clk) begin
        if (clr) begin
            state        <= S_IDLE;
            cond_r       <= COND_ZR;
            bif.taken    <= 1'b0;
            bif.busy     <= 1'b0;
            bif.done     <= 1'b0;
            bif.gra      <= 1'b0;
            bif.rout     <= 1'b0;
            bif.con_in   <= 1'b0;
            bif.pc_out   <= 1'b0;
            bif.y_in     <= 1'b0;
            bif.c_out    <= 1'b0;
            bif.alu_add  <= 1'b0;
            bif.z_in     <= 1'b0;
            bif.zlow_out <= 1'b0;
            bif.pc_in    <= 1'b0;
        end else begin
            bif.done     <= 1'b0;
            bif.gra      <= 1'b0;
            bif.rout     <= 1'b0;
            bif.con_in   <= 1'b0;
            bif.pc_out   <= 1'b0;
            bif.y_in     <= 1'b0;
            bif.c_out    <= 1'b0;
            bif.alu_add  <= 1'b0;
            bif.z_in     <= 1'b0;
            bif.zlow_out <= 1'b0;
            bif.pc_in    <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bif.start) begin
                        state      <= S_EVAL;
                        cond_r     <= bif.ir_c2;
                        bif.taken  <= 1'b0;
                        bif.busy   <= 1'b1;
                        bif.gra    <= 1'b1;
                        bif.rout   <= 1'b1;
                        bif.con_in <= 1'b1;
                    end
                end
                S_EVAL: begin
                    state      <= S_LDPC;
                    bif.taken  <= met;
                    bif.busy   <= 1'b1;
                    bif.pc_out <= 1'b1;
                    bif.y_in   <= 1'b1;
                end
                S_LDPC: begin
                    state       <= S_ADD;
                    bif.busy    <= 1'b1;
                    bif.c_out   <= 1'b1;
                    bif.alu_add <= 1'b1;
                    bif.z_in    <= 1'b1;
                end
                S_ADD: begin
                    state        <= S_UPD;
                    bif.busy     <= 1'b1;
                    bif.done     <= 1'b1;
                    bif.zlow_out <= bif.taken;
                    bif.pc_in    <= bif.taken;
                end
                default: begin
                    state    <= S_IDLE;
                    bif.busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_branch_seq.sv
// tb/tb_branch_seq.sv - directed self-checking bench for branch_seq
module tb_branch_seq;

    logic clk;
    logic clr;
    int   n_cmp;
    int   n_bad;

    branch_seq_if #(.BITS(32)) bif ();

    branch_seq #(.BITS(32)) dut (
        .clk (clk),
        .clr (clr),
        .bif (bif.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // {gra,rout,con_in,pc_out,y_in,c_out,alu_add,z_in,zlow_out,pc_in,done,busy}
    function automatic logic [11:0] obs_vec();
        return {bif.gra, bif.rout, bif.con_in, bif.pc_out, bif.y_in, bif.c_out,
                bif.alu_add, bif.z_in, bif.zlow_out, bif.pc_in, bif.done, bif.busy};
    endfunction

    // Expected outputs in cycle k after an accepted start (k = 1..5).
    function automatic logic [11:0] exp_vec(input int k, input logic t);
        case (k)
            1:       return 12'b1110_0000_0001;
            2:       return 12'b0001_1000_0001;
            3:       return 12'b0000_0111_0001;
            4:       return {8'b0000_0000, t, t, 2'b11};
            default: return 12'b0000_0000_0000;
        endcase
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // One full branch: start in cycle 0, bval on bus in EVAL, noise elsewhere.
    task automatic run_branch(input logic [1:0] c2, input logic [31:0] bval,
                              input logic [31:0] noise, input logic exp_t, input string name);
        int dones;
        dones = 0;
        next_cycle();
        bif.start = 1'b1;
        bif.ir_c2 = c2;
        bif.bus   = noise;
        for (int k = 1; k <= 5; k++) begin
            next_cycle();
            bif.start = 1'b0;
            bif.ir_c2 = ~c2;
            bif.bus   = (k == 1) ? bval : noise;
            n_cmp++;
            if (obs_vec() !== exp_vec(k, exp_t)) begin
                n_bad++;
                $display("FAIL %s strobes cycle %0d: got %b want %b", name, k, obs_vec(), exp_vec(k, exp_t));
            end
            if (k >= 2) begin
                n_cmp++;
                if (bif.taken !== exp_t) begin
                    n_bad++;
                    $display("FAIL %s taken cycle %0d: got %b want %b", name, k, bif.taken, exp_t);
                end
            end
            if (bif.done === 1'b1) dones++;
        end
        n_cmp++;
        if (dones !== 1) begin
            n_bad++;
            $display("FAIL %s done count: got %0d want 1", name, dones);
        end
    endtask

    task automatic test_reset();
        clr       = 1'b1;
        bif.start = 1'b1;
        bif.ir_c2 = 2'b00;
        bif.bus   = 32'h0;
        next_cycle();
        next_cycle();
        n_cmp++;
        if (obs_vec() !== 12'h000 || bif.taken !== 1'b0) begin
            n_bad++;
            $display("FAIL reset outputs: got %b taken %b want all 0", obs_vec(), bif.taken);
        end
        bif.start = 1'b0;
        clr       = 1'b0;
        next_cycle();
        n_cmp++;
        if (obs_vec() !== 12'h000) begin
            n_bad++;
            $display("FAIL reset idle: got %b want 000000000000", obs_vec());
        end
    endtask

    task automatic test_conditions();
        run_branch(2'b00, 32'h0000_0000, 32'h0000_0000, 1'b1, "zr_zero");
        run_branch(2'b01, 32'h0000_0000, 32'h0000_0000, 1'b0, "nz_zero");
        run_branch(2'b10, 32'h0000_0000, 32'h0000_0000, 1'b1, "pl_zero");
        run_branch(2'b10, 32'h8000_0000, 32'h0000_0000, 1'b0, "pl_neg");
        run_branch(2'b11, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, "mi_neg");
        run_branch(2'b11, 32'h7FFF_FFFF, 32'h0000_0000, 1'b0, "mi_pos");
        run_branch(2'b01, 32'h0000_0100, 32'h0000_0000, 1'b1, "nz_nonzero");
    endtask

    task automatic test_bus_noise();
        run_branch(2'b00, 32'h0000_0000, 32'h1234_5678, 1'b1, "noise_zr_taken");
        run_branch(2'b00, 32'h0000_0010, 32'h0000_0000, 1'b0, "noise_zr_not");
    endtask

    task automatic test_back_to_back();
        int dones;
        dones = 0;
        next_cycle();
        bif.start = 1'b1;
        bif.ir_c2 = 2'b01;
        bif.bus   = 32'h0;
        for (int k = 1; k <= 5; k++) begin
            next_cycle();
            // re-pulses with a different code must not restart or relatch
            bif.start = (k == 2 || k == 4) ? 1'b1 : 1'b0;
            bif.ir_c2 = 2'b11;
            bif.bus   = (k == 1) ? 32'h0000_0003 : 32'h0;
            n_cmp++;
            if (obs_vec() !== exp_vec(k, 1'b1)) begin
                n_bad++;
                $display("FAIL b2b strobes cycle %0d: got %b want %b", k, obs_vec(), exp_vec(k, 1'b1));
            end
            if (bif.done === 1'b1) dones++;
        end
        n_cmp++;
        if (dones !== 1) begin
            n_bad++;
            $display("FAIL b2b done count: got %0d want 1", dones);
        end
        n_cmp++;
        if (bif.taken !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b taken: got %b want 1", bif.taken);
        end
        // start in cycle 5 (IDLE) is accepted
        bif.start = 1'b1;
        bif.ir_c2 = 2'b00;
        next_cycle();
        bif.start = 1'b0;
        n_cmp++;
        if (obs_vec() !== exp_vec(1, 1'b0) || bif.taken !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b restart: got %b taken %b want %b taken 0", obs_vec(), bif.taken, exp_vec(1, 1'b0));
        end
        for (int k = 2; k <= 5; k++) next_cycle();
    endtask

    task automatic test_clr_mid();
        next_cycle();
        bif.start = 1'b1;
        bif.ir_c2 = 2'b00;
        bif.bus   = 32'h0;
        for (int k = 1; k <= 3; k++) begin
            next_cycle();
            bif.start = 1'b0;
        end
        n_cmp++;
        if (obs_vec() !== exp_vec(3, 1'b1)) begin
            n_bad++;
            $display("FAIL clr pre ADD: got %b want %b", obs_vec(), exp_vec(3, 1'b1));
        end
        clr = 1'b1;
        next_cycle();
        clr = 1'b0;
        n_cmp++;
        if (obs_vec() !== 12'h000 || bif.taken !== 1'b0) begin
            n_bad++;
            $display("FAIL clr abort: got %b taken %b want all 0", obs_vec(), bif.taken);
        end
        next_cycle();
        n_cmp++;
        if (obs_vec() !== 12'h000) begin
            n_bad++;
            $display("FAIL clr no done: got %b want 000000000000", obs_vec());
        end
        run_branch(2'b00, 32'h0000_0000, 32'hDEAD_BEEF, 1'b1, "after_clr");
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        clr       = 1'b0;
        bif.start = 1'b0;
        bif.ir_c2 = 2'b00;
        bif.bus   = 32'h0;
        test_reset();
        test_conditions();
        test_bus_noise();
        test_back_to_back();
        test_clr_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
